// File: rtl/a1csa_carry_pipe.sv
// Two-stage elastic group-carry resolver driving the add-one carry-select `sel` inputs.
// Optional signed-overflow output enabled by defining A1CSA_OVF_EN.

module a1csa_carry_cell (
  input  logic g,
  input  logic p,
  input  logic ci,
  output logic co
);
  assign co = g | (p & ci);
endmodule

module a1csa_carry_pipe #(
  parameter int G = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           cin,
  input  logic [G-1:0]   gen,
  input  logic [G-1:0]   prop,
  input  logic [G*W-1:0] presum,
`ifdef A1CSA_OVF_EN
  input  logic           a_msb,
  input  logic           b_msb,
  output logic           ovf,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [G-1:0]   sel,
  output logic [G*W-1:0] presum_q,
  output logic           cout
);

  logic           v1;
  logic           cin1;
  logic [G-1:0]   gen1, prop1;
  logic [G*W-1:0] presum1;
  logic           s2_ready, acc, adv;
  logic [G:0]     c;

  assign s2_ready = !out_valid | out_ready;
  assign in_ready = !v1 | s2_ready;
  assign acc      = in_valid & in_ready;
  assign adv      = v1 & s2_ready;

  // S1: capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      cin1    <= 1'b0;
      gen1    <= '0;
      prop1   <= '0;
      presum1 <= '0;
    end else begin
      if (acc)      v1 <= 1'b1;
      else if (adv) v1 <= 1'b0;
      if (acc) begin
        cin1    <= cin;
        gen1    <= gen;
        prop1   <= prop;
        presum1 <= presum;
      end
    end
  end

  // Ripple lookahead across groups: one cell per slice, c[i] is slice i's select.
  assign c[0] = cin1;
  a1csa_carry_cell u_cell [G-1:0] (
    .g  (gen1),
    .p  (prop1),
    .ci (c[G-1:0]),
    .co (c[G:1])
  );

  // S2: carry result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sel       <= '0;
      presum_q  <= '0;
      cout      <= 1'b0;
    end else begin
      if (adv)            out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (adv) begin
        sel      <= c[G-1:0];
        presum_q <= presum1;
        cout     <= c[G];
      end
    end
  end

`ifdef A1CSA_OVF_EN
  logic a1, b1, fmsb;

  // Final MSB after the top slice's add-one correction.
  assign fmsb = presum1[G*W-1] ^ (c[G-1] & (&presum1[G*W-2:(G-1)*W]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1  <= 1'b0;
      b1  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (acc) begin
        a1 <= a_msb;
        b1 <= b_msb;
      end
      if (adv) ovf <= (a1 == b1) & (fmsb != a1);
    end
  end
`endif

endmodule

// File: tb/tb_a1csa_carry_pipe.sv
// Directed self-checking bench for a1csa_carry_pipe (G=4, W=4); honours A1CSA_OVF_EN.

module tb_a1csa_carry_pipe;
  localparam int G = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, cin;
  logic [G-1:0]   gen, prop;
  logic [G*W-1:0] presum;
  logic           out_valid, out_ready;
  logic [G-1:0]   sel;
  logic [G*W-1:0] presum_q;
  logic           cout;
`ifdef A1CSA_OVF_EN
  logic           a_msb, b_msb, ovf;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  a1csa_carry_pipe #(.G(G), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .gen       (gen),
    .prop      (prop),
    .presum    (presum),
`ifdef A1CSA_OVF_EN
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .presum_q  (presum_q),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_one(input string tag, input logic c, input logic [3:0] g, input logic [3:0] p,
                          input logic [15:0] ps, input logic am, input logic bm,
                          input logic [3:0] esel, input logic ecout, input logic eovf);
    @(negedge clk);
    in_valid = 1'b1; cin = c; gen = g; prop = p; presum = ps;
`ifdef A1CSA_OVF_EN
    a_msb = am; b_msb = bm;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sel"}, sel, esel);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_presum_q"}, presum_q, ps);
`ifdef A1CSA_OVF_EN
    check({tag, "_ovf"}, ovf, eovf);
`endif
  endtask

  // Handshake-accurate stream: item k carries presum=base+k, cin=k[0], gen=0, prop=1111,
  // so the expected result is sel = cin ? 1111 : 0000 and cout = cin.
  task automatic run_stream(input int n, input int st_lo, input int st_hi, input logic [15:0] base,
                            output int got, output bit order_ok, output bit ready_dropped,
                            output bit stable_ok, output int valid_run);
    int sent = 0;
    int run = 0;
    bit have_snap = 0;
    logic [15:0] snap_p;
    logic [3:0]  snap_s;
    logic        snap_c;
    got = 0; order_ok = 1; ready_dropped = 0; stable_ok = 1; valid_run = 0;
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      cin = sent[0]; gen = 4'h0; prop = 4'hF; presum = base + sent[15:0];
      #1;
      if (out_valid) run++; else run = 0;
      if (run > valid_run) valid_run = run;
      if (out_valid && !out_ready) begin
        if (!have_snap) begin
          snap_p = presum_q; snap_s = sel; snap_c = cout; have_snap = 1;
        end else if (presum_q !== snap_p || sel !== snap_s || cout !== snap_c) stable_ok = 0;
      end else have_snap = 0;
      if (out_valid && out_ready) begin
        if (presum_q !== base + got[15:0] || sel !== (got[0] ? 4'hF : 4'h0) || cout !== got[0])
          order_ok = 0;
        got++;
      end
      if (!in_ready) ready_dropped = 1;
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    int got, vrun;
    bit ord, drop, stab, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0;
    gen = '0; prop = '0; presum = '0;
`ifdef A1CSA_OVF_EN
    a_msb = 1'b0; b_msb = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sel", sel, 4'h0);
    check("rst_presum_q", presum_q, 16'h0);
    check("rst_cout", cout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    // 0x00FF + 0x0001
    send_one("v1", 1'b0, 4'b0001, 4'b0010, 16'h00F0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
    // 0xFFFF + 0x0000 + 1
    send_one("v2", 1'b1, 4'b0000, 4'b1111, 16'hFFFF, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
    // 0x7FFF + 0x0001: top slice 7+0 does not propagate, so prop=0110
    send_one("v3", 1'b0, 4'b0001, 4'b0110, 16'h7FF0, 1'b0, 1'b0, 4'b1110, 1'b0, 1'b1);

    run_stream(8, 1000, -1, 16'h1000, got, ord, drop, stab, vrun);
    check("stream_count", got, 8);
    check("stream_order", ord, 1'b1);
    check("stream_in_ready_held", drop, 1'b0);
    check("stream_consecutive", vrun, 8);

    run_stream(6, 2, 6, 16'h2000, got, ord, drop, stab, vrun);
    check("stall_count", got, 6);
    check("stall_order", ord, 1'b1);
    check("stall_in_ready_fell", drop, 1'b1);
    check("stall_stable", stab, 1'b1);

    // Fill both stages under stall, then reset asynchronously mid-cycle
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; cin = 1'b1; gen = 4'h0; prop = 4'hF; presum = 16'hABCD;
    @(negedge clk);
    presum = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_pre_valid", out_valid, 1'b1);
    check("midrst_pre_in_ready", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sel", sel, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    check("midrst_no_stale", stale, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
